// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing controller.
// Both axes use the same region sequence, so one enum backs both state types.
package video_timing_pkg;

   typedef enum logic [1:0] {
      RegAct   = 2'd0,
      RegFront = 2'd1,
      RegSync  = 2'd2,
      RegBack  = 2'd3
   } region_t;

   typedef region_t h_state_t;
   typedef region_t v_state_t;

   typedef struct packed {
      int unsigned h_active;
      int unsigned h_front;
      int unsigned h_sync;
      int unsigned h_back;
      int unsigned v_active;
      int unsigned v_front;
      int unsigned v_sync;
      int unsigned v_back;
   } timing_t;

   localparam timing_t VGA_640X480 = '{
      h_active: 640, h_front: 16, h_sync: 96, h_back: 48,
      v_active: 480, v_front: 10, v_sync: 2,  v_back: 33
   };

   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
      return active + front + sync + back;
   endfunction

endpackage

// File: rtl/video_timing_ctrl_timing_axis.sv
// Counter plus region FSM for one raster axis (horizontal or vertical).
// i_clear returns the axis to the start of the active region and wins over i_step.
module timing_axis
   import video_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FRONT  = 16,
   parameter int unsigned SYNC   = 96,
   parameter int unsigned BACK   = 48,
   parameter int unsigned CNT_W  = 12
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_step,
   input  logic             i_clear,
   output logic [CNT_W-1:0] o_count,
   output region_t          o_state,
   output logic             o_last_of_total,
   output logic             o_in_sync
);

   localparam int unsigned TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

   if (ACTIVE == 0 || FRONT == 0 || SYNC == 0 || BACK == 0) begin : g_zero_region
      $error("timing_axis: every region must be at least one step wide");
   end

   if (longint'(TOTAL) > (longint'(1) << CNT_W)) begin : g_cnt_too_narrow
      $error("timing_axis: CNT_W cannot hold TOTAL-1");
   end

   // Last count of each region; the FSM leaves a region on the step that consumes it.
   localparam logic [CNT_W-1:0] LAST_ACT   = CNT_W'(ACTIVE - 1);
   localparam logic [CNT_W-1:0] LAST_FRONT = CNT_W'(ACTIVE + FRONT - 1);
   localparam logic [CNT_W-1:0] LAST_SYNC  = CNT_W'(ACTIVE + FRONT + SYNC - 1);
   localparam logic [CNT_W-1:0] LAST_TOTAL = CNT_W'(TOTAL - 1);

   logic [CNT_W-1:0] r_cnt;
   region_t          r_state;
   logic             w_last;

   assign w_last = (r_cnt == LAST_TOTAL);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_state <= RegAct;
      end else if (i_clear) begin
         r_cnt   <= '0;
         r_state <= RegAct;
      end else if (i_step) begin
         r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
         unique case (r_state)
            RegAct:   if (r_cnt == LAST_ACT)   r_state <= RegFront;
            RegFront: if (r_cnt == LAST_FRONT) r_state <= RegSync;
            RegSync:  if (r_cnt == LAST_SYNC)  r_state <= RegBack;
            RegBack:  if (w_last)              r_state <= RegAct;
         endcase
      end
   end

   assign o_count         = r_cnt;
   assign o_state         = r_state;
   assign o_last_of_total = w_last;
   assign o_in_sync       = (r_state == RegSync);

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator feeding the three TMDS encoders: syncs, video enable and coordinates.
// All outputs are registered decodes of the counter position, one cycle behind the counters.
module video_timing_ctrl
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_640X480.h_active,
   parameter int unsigned H_FRONT  = VGA_640X480.h_front,
   parameter int unsigned H_SYNC   = VGA_640X480.h_sync,
   parameter int unsigned H_BACK   = VGA_640X480.h_back,
   parameter int unsigned V_ACTIVE = VGA_640X480.v_active,
   parameter int unsigned V_FRONT  = VGA_640X480.v_front,
   parameter int unsigned V_SYNC   = VGA_640X480.v_sync,
   parameter int unsigned V_BACK   = VGA_640X480.v_back,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CNT_W    = 12
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_restart,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_ve,
   output logic [1:0]       o_control,
   output logic [CNT_W-1:0] o_x,
   output logic [CNT_W-1:0] o_y,
   output logic             o_line_start,
   output logic             o_frame_start,
   output logic [7:0]       o_frame_cnt
);

   logic [CNT_W-1:0] w_h_cnt;
   logic [CNT_W-1:0] w_v_cnt;
   h_state_t         w_h_state;
   v_state_t         w_v_state;
   logic             w_h_last;
   logic             w_v_last;
   logic             w_h_in_sync;
   logic             w_v_in_sync;
   logic             w_clear;
   logic             w_active;

   assign w_clear  = i_en & i_restart;
   assign w_active = (w_h_state == RegAct) && (w_v_state == RegAct);

   timing_axis #(
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK),
      .CNT_W  (CNT_W)
   ) u_h_axis (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_step          (i_en),
      .i_clear         (w_clear),
      .o_count         (w_h_cnt),
      .o_state         (w_h_state),
      .o_last_of_total (w_h_last),
      .o_in_sync       (w_h_in_sync)
   );

   // Vertical axis advances only on the horizontal wrap.
   timing_axis #(
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK),
      .CNT_W  (CNT_W)
   ) u_v_axis (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_step          (i_en & w_h_last),
      .i_clear         (w_clear),
      .o_count         (w_v_cnt),
      .o_state         (w_v_state),
      .o_last_of_total (w_v_last),
      .o_in_sync       (w_v_in_sync)
   );

   logic             r_hsync;
   logic             r_vsync;
   logic             r_ve;
   logic [CNT_W-1:0] r_x;
   logic [CNT_W-1:0] r_y;
   logic             r_line_start;
   logic             r_frame_start;
   logic [7:0]       r_frame_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hsync       <= ~HS_POL;
         r_vsync       <= ~VS_POL;
         r_ve          <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= '0;
      end else if (!i_en) begin
         // Frozen raster: pulses and enable drop, syncs keep their level.
         r_ve          <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (i_restart) begin
         r_hsync       <= ~HS_POL;
         r_vsync       <= ~VS_POL;
         r_ve          <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_hsync       <= w_h_in_sync ? HS_POL : ~HS_POL;
         r_vsync       <= w_v_in_sync ? VS_POL : ~VS_POL;
         r_ve          <= w_active;
         r_x           <= w_active ? w_h_cnt : '0;
         r_y           <= w_active ? w_v_cnt : '0;
         r_line_start  <= (w_h_cnt == '0);
         r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
         if (w_h_last && w_v_last) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_control     = {r_vsync, r_hsync};
   assign o_ve          = r_ve;
   assign o_x           = r_x;
   assign o_y           = r_y;
   assign o_line_start  = r_line_start;
   assign o_frame_start = r_frame_start;
   assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Scoreboard bench: a default 640x480 instance and a tiny 7x5 active-high instance,
// each checked every cycle against a raster model built from region arithmetic.
module tb_video_timing_ctrl;
   import video_timing_pkg::*;

   localparam timing_t T_SMALL = '{
      h_active: 4, h_front: 1, h_sync: 1, h_back: 1,
      v_active: 2, v_front: 1, v_sync: 1, v_back: 1
   };

   typedef struct packed {
      logic        ve;
      logic        hs;
      logic        vs;
      logic [1:0]  ctrl;
      logic [11:0] x;
      logic [11:0] y;
      logic        ls;
      logic        fs;
      logic [7:0]  fc;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst[2];
   logic en[2];
   logic rs[2];

   logic        d0_hs, d0_vs, d0_ve, d0_ls, d0_fs;
   logic [1:0]  d0_ctrl;
   logic [11:0] d0_x, d0_y;
   logic [7:0]  d0_fc;
   logic        d1_hs, d1_vs, d1_ve, d1_ls, d1_fs;
   logic [1:0]  d1_ctrl;
   logic [11:0] d1_x, d1_y;
   logic [7:0]  d1_fc;

   video_timing_ctrl u_dut_vga (
      .i_clk         (clk),
      .i_rst         (rst[0]),
      .i_en          (en[0]),
      .i_restart     (rs[0]),
      .o_hsync       (d0_hs),
      .o_vsync       (d0_vs),
      .o_ve          (d0_ve),
      .o_control     (d0_ctrl),
      .o_x           (d0_x),
      .o_y           (d0_y),
      .o_line_start  (d0_ls),
      .o_frame_start (d0_fs),
      .o_frame_cnt   (d0_fc)
   );

   video_timing_ctrl #(
      .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
      .V_ACTIVE (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
      .HS_POL   (1'b1), .VS_POL (1'b1), .CNT_W (12)
   ) u_dut_small (
      .i_clk         (clk),
      .i_rst         (rst[1]),
      .i_en          (en[1]),
      .i_restart     (rs[1]),
      .o_hsync       (d1_hs),
      .o_vsync       (d1_vs),
      .o_ve          (d1_ve),
      .o_control     (d1_ctrl),
      .o_x           (d1_x),
      .o_y           (d1_y),
      .o_line_start  (d1_ls),
      .o_frame_start (d1_fs),
      .o_frame_cnt   (d1_fc)
   );

   obs_t obs0, obs1;
   assign obs0 = {d0_ve, d0_hs, d0_vs, d0_ctrl, d0_x, d0_y, d0_ls, d0_fs, d0_fc};
   assign obs1 = {d1_ve, d1_hs, d1_vs, d1_ctrl, d1_x, d1_y, d1_ls, d1_fs, d1_fc};

   timing_t    tp[2];
   bit         hpol[2];
   bit         vpol[2];
   int         mh[2];
   int         mv[2];
   logic [7:0] mfc[2];
   obs_t       last_e[2];
   obs_t       q0[$];
   obs_t       q1[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic check(input string name, input obs_t got, input obs_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got ve=%0b hs=%0b vs=%0b ctrl=%0b x=%0d y=%0d ls=%0b fs=%0b fc=%0d | required ve=%0b hs=%0b vs=%0b ctrl=%0b x=%0d y=%0d ls=%0b fs=%0b fc=%0d",
                  name, $time, got.ve, got.hs, got.vs, got.ctrl, got.x, got.y, got.ls, got.fs,
                  got.fc, exp.ve, exp.hs, exp.vs, exp.ctrl, exp.x, exp.y, exp.ls, exp.fs, exp.fc);
      end
   endtask

   function automatic obs_t reset_val(input int d);
      obs_t e = '0;
      e.hs   = ~hpol[d];
      e.vs   = ~vpol[d];
      e.ctrl = {e.vs, e.hs};
      return e;
   endfunction

   task automatic push(input int d, input obs_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Drive one clock of stimulus and queue what the following edge must produce.
   task automatic step(input int d, input bit go, input bit restart);
      obs_t    e;
      timing_t t = tp[d];
      int ha  = int'(t.h_active);
      int hs0 = ha + int'(t.h_front);
      int hs1 = hs0 + int'(t.h_sync);
      int ht  = hs1 + int'(t.h_back);
      int va  = int'(t.v_active);
      int vs0 = va + int'(t.v_front);
      int vs1 = vs0 + int'(t.v_sync);
      int vt  = vs1 + int'(t.v_back);
      @(negedge clk);
      en[d] = go;
      rs[d] = restart;
      e    = last_e[d];
      e.ve = 1'b0;
      e.ls = 1'b0;
      e.fs = 1'b0;
      e.x  = '0;
      e.y  = '0;
      if (go && restart) begin
         e.hs  = ~hpol[d];
         e.vs  = ~vpol[d];
         mh[d] = 0;
         mv[d] = 0;
      end else if (go) begin
         e.ve = (mh[d] < ha) && (mv[d] < va);
         if (e.ve) begin
            e.x = 12'(mh[d]);
            e.y = 12'(mv[d]);
         end
         e.ls = (mh[d] == 0);
         e.fs = (mh[d] == 0) && (mv[d] == 0);
         e.hs = (mh[d] >= hs0 && mh[d] < hs1) ? hpol[d] : ~hpol[d];
         e.vs = (mv[d] >= vs0 && mv[d] < vs1) ? vpol[d] : ~vpol[d];
         mh[d]++;
         if (mh[d] == ht) begin
            mh[d] = 0;
            mv[d]++;
            if (mv[d] == vt) begin
               mv[d] = 0;
               mfc[d]++;
            end
         end
      end
      e.fc      = mfc[d];
      e.ctrl    = {e.vs, e.hs};
      last_e[d] = e;
      push(d, e);
   endtask

   task automatic run_to(input int d, input int h, input int v);
      while (!(mh[d] == h && (v < 0 || mv[d] == v))) step(d, 1'b1, 1'b0);
   endtask

   // Reset asserted away from any edge; outputs must clear before the next edge.
   task automatic do_reset(input int d);
      @(negedge clk);
      rst[d] = 1'b1;
      en[d]  = 1'b0;
      rs[d]  = 1'b0;
      #1;
      check(d == 0 ? "async_reset_vga" : "async_reset_small", d == 0 ? obs0 : obs1,
            reset_val(d));
      mh[d]     = 0;
      mv[d]     = 0;
      mfc[d]    = '0;
      last_e[d] = reset_val(d);
      push(d, reset_val(d));
      @(negedge clk);
      rst[d] = 1'b0;
      push(d, reset_val(d));
   endtask

   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("raster_vga", obs0, e);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("raster_small", obs1, e);
         end
      end
   end

   initial begin
      tp[0]   = VGA_640X480;
      tp[1]   = T_SMALL;
      hpol[0] = 1'b0;
      vpol[0] = 1'b0;
      hpol[1] = 1'b1;
      vpol[1] = 1'b1;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;
         en[d]  = 1'b0;
         rs[d]  = 1'b0;
      end

      // 640x480: pause mid-line, restart mid-frame, random enable, async reset mid-active.
      do_reset(0);
      run_to(0, 300, 10);
      repeat (7) step(0, 1'b0, 1'b0);
      run_to(0, 500, 12);
      step(0, 1'b1, 1'b1);
      repeat (2400) step(0, ($urandom_range(0, 9) != 0), 1'b0);
      run_to(0, 123, -1);
      do_reset(0);
      repeat (900) step(0, 1'b1, 1'b0);
      step(0, 1'b0, 1'b0);

      // 7x5 active-high: 300 clean frames, restart on the wrap, then random en/restart.
      do_reset(1);
      repeat (300 * 35) step(1, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      n_cmp++;
      if (d1_fc !== 8'd44) begin
         n_bad++;
         $display("FAIL frame_cnt_wrap: got %0d, required 44", d1_fc);
      end
      run_to(1, 6, 4);
      step(1, 1'b1, 1'b1);
      repeat (2000) step(1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
      step(1, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0",
                  q0.size(), q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
- Sequences the three per-channel TMDS encoders.
- Generates raster timing (hsync, vsync, video-enable) and pixel coordinates for one video mode.
- Drives each encoder's i_ve and the blue channel's i_control = {vs,hs}. Red and green i_control are tied to 0 at the top level.
- Sits between the pixel source (pattern generator or framebuffer reader) and the encoders, in the pixel-clock domain.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync (0 = active-low)
- VS_POL, 0, asserted level of vsync (0 = active-low)
- CNT_W, 12, width of the h/v counters and coordinate outputs

Ports:
- i_clk  input  1  pixel clock
- i_rst  input  1  reset; asynchronous, active-high
- i_en  input  1  advance enable; 0 freezes the raster
- i_restart  input  1  synchronous request to restart at the top of the frame
- o_hsync  output  1  horizontal sync at HS_POL polarity
- o_vsync  output  1  vertical sync at VS_POL polarity
- o_ve  output  1  video enable to all encoders' i_ve
- o_control  output  2  {o_vsync, o_hsync} for the blue encoder's i_control
- o_x  output  CNT_W  pixel column; valid only while o_ve=1
- o_y  output  CNT_W  pixel row; valid only while o_ve=1
- o_line_start  output  1  one-cycle pulse at h=0 of every line
- o_frame_start  output  1  one-cycle pulse at h=0, v=0
- o_frame_cnt  output  8  frame counter; wraps 255->0

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800 by default); V_TOTAL = sum of the four V parameters (525 by default).
- Reset (async assert, sync release):
  - h_cnt=0, v_cnt=0, h_state=H_ACT, v_state=V_ACT, o_frame_cnt=0.
  - o_ve=0, o_x=0, o_y=0, o_line_start=0, o_frame_start=0.
  - o_hsync=~HS_POL, o_vsync=~VS_POL, o_control matches the deasserted syncs.
- Horizontal FSM:
  - States H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT.
  - Each transition occurs when h_cnt reaches the last pixel of the current region.
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
- Vertical FSM:
  - States V_ACT -> V_FP -> V_SYNC -> V_BP -> V_ACT.
  - v_cnt advances only on the cycle h_cnt wraps; it counts 0..V_TOTAL-1, then wraps to 0.
  - o_frame_cnt increments on the v_cnt wrap.
- Output timing:
  - On each clock edge with i_en=1, outputs register the decode of the current (h_cnt, v_cnt), and the counters then advance.
  - Latency: 1 cycle from counter value to output. The first enabled edge after reset presents h=0, v=0: o_ve=1, o_frame_start=1, o_line_start=1.
- Decode:
  - o_ve = (h_state==H_ACT) && (v_state==V_ACT).
  - hsync is asserted while h_state==H_SYNC, on every line including vertical blanking.
  - vsync is asserted while v_state==V_SYNC for whole lines; it changes at h=0.
  - o_x=h_cnt and o_y=v_cnt when o_ve=1; both hold 0 otherwise.
- i_en=0:
  - Counters, FSMs and o_frame_cnt hold.
  - o_ve, o_line_start and o_frame_start are forced to 0; sync outputs hold their last value.
  - Resuming continues from the held position, with no skipped pixel.
- i_restart=1 (sampled only with i_en=1):
  - Next state is h_cnt=0, v_cnt=0, both FSMs in ACT.
  - Outputs on that edge show a blanking cycle: o_ve=0, syncs deasserted.
  - o_frame_cnt does not increment.
  - i_restart has priority over normal advance, including on the wrap cycle.
- Reset mid-line: asserting i_rst forces the reset values immediately, without waiting for a clock edge.
- Boundary:
  - Any single region parameter =1 must work: that state lasts one pixel or line.
  - Zero-width regions are illegal; elaboration fails via a static assertion.
  - CNT_W must hold both H_TOTAL-1 and V_TOTAL-1; checked at elaboration.
  - The blue encoder clears its DC tally whenever i_ve=0, so o_ve must drop for at least one cycle per line. Any legal parameter set guarantees this.

Decomposition:
- Package video_timing_pkg holds:
  - the h_state_t and v_state_t enums;
  - a struct of the eight timing values;
  - the default 640x480@60 constant;
  - a TOTAL() function.
- Sub-module timing_axis:
  - One parameterised counter+FSM instance for an axis, with an i_step input.
  - Produces count, state, last_of_total and in_sync.
  - Instantiated twice: the horizontal instance is stepped by i_en; the vertical instance is stepped by the horizontal wrap.

Test Plan:
- Reset, then i_en=1 for 800x525 cycles:
  - o_ve high for exactly 640x480 cycles;
  - o_hsync low for 96 cycles starting at h=656 on every line;
  - o_vsync low for lines 490-491;
  - o_frame_start pulses once; o_frame_cnt 0->1.
- Sample o_x/o_y on o_ve cycles: first (0,0), last (639,479), strictly raster-ordered with no gaps; o_control == {o_vsync,o_hsync} every cycle.
- Toggle i_en low for 7 cycles at h=300, v=10: o_ve=0 during the pause; on resume o_x=300, o_y=10; frame length measured in enabled cycles stays 420000.
- Pulse i_restart at h=500, v=200: next output cycle has o_ve=0; the following cycle has o_frame_start=1 and (0,0); o_frame_cnt unchanged.
- Assert i_rst asynchronously mid-active (h=123): outputs return to reset values before the next edge; release gives o_frame_start on the first enabled edge.
- Small parameters H=4,1,1,1 and V=2,1,1,1 with HS_POL=VS_POL=1: hand-checked 7x5 waveform matches cycle-for-cycle; 300 frames wrap o_frame_cnt 255->0->44.
